// File: rtl/inst_sram_resp_if.sv
// Instruction SRAM bus: fetch-side request signals plus response/status returned by the SRAM.
// master = fetch stage, slave = inst_sram_resp.
interface inst_sram_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        init_done;
  logic        acc_err;
  logic [31:0] err_addr;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata, init_done, acc_err, err_addr
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata, init_done, acc_err, err_addr
  );
endinterface

// File: rtl/inst_sram_resp.sv
// Instruction SRAM with power-up zero-fill, byte writes, held read data and access-error capture.
// Optional macro INST_SRAM_WFIRST_EN: a valid write also returns the merged word on rdata (write-first).
//
// state   | meaning
// ST_INIT | zero-filling one word per cycle, requests ignored
// ST_RUN  | normal access, init_done high
module inst_sram_resp #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
  input logic              clk,
  input logic              resetn,
  inst_sram_resp_if.slave  sram
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              acc_err_q, acc_err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic [31:0]       mem [DEPTH];

  logic              in_range;
  logic              aligned;
  logic              valid;
  logic              is_write;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       cur_word;
  logic [31:0]       merged;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign in_range = (sram.inst_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign aligned  = (sram.inst_sram_addr[1:0] == 2'b00);
  assign valid    = sram.inst_sram_en && in_range && aligned;
  assign is_write = (sram.inst_sram_we != 4'b0000);
  assign idx      = sram.inst_sram_addr[ADDR_W+1:2];
  assign cur_word = mem[idx];

  // Byte merge happens here so the array only ever sees full-word writes.
  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (sram.inst_sram_we[b]) begin
        merged[8*b +: 8] = sram.inst_sram_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    acc_err_d  = 1'b0;
    err_addr_d = err_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = cnt_q;
    mem_wdata  = 32'h0;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = 32'h0;
        // Counter parks at the last index; it never wraps back to 0 in RUN.
        if (&cnt_q) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      ST_RUN: begin
        if (valid) begin
          if (is_write) begin
            mem_we    = 1'b1;
            mem_waddr = idx;
            mem_wdata = merged;
`ifdef INST_SRAM_WFIRST_EN
            rdata_d   = merged;
`else
            rdata_d   = rdata_q;
`endif
          end else begin
            rdata_d = cur_word;
          end
        end else if (sram.inst_sram_en) begin
          acc_err_d  = 1'b1;
          err_addr_d = sram.inst_sram_addr;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rdata_q    <= 32'h0;
      acc_err_q  <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      acc_err_q  <= acc_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Array has no reset; the INIT zero-fill is what defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign sram.inst_sram_rdata = rdata_q;
  assign sram.init_done       = (state_q == ST_RUN);
  assign sram.acc_err         = acc_err_q;
  assign sram.err_addr        = err_addr_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp (ADDR_W=4): vector table through a one-deep scoreboard
// plus hand-written reset / zero-fill sequences.
module tb_inst_sram_resp;
  localparam int unsigned AW   = 4;
  localparam logic [31:0] BASE = 32'h1c000000;
`ifdef INST_SRAM_WFIRST_EN
  localparam bit WFIRST = 1'b1;
`else
  localparam bit WFIRST = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_sram_resp_if sram_if ();

  inst_sram_resp #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sram   (sram_if.slave)
  );

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_err_addr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    sram_if.inst_sram_en    = en;
    sram_if.inst_sram_we    = we;
    sram_if.inst_sram_addr  = addr;
    sram_if.inst_sram_wdata = wdata;
  endtask

  task automatic add_row(input logic en, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input logic [31:0] exp_ea);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rd; v.exp_err = exp_err; v.exp_err_addr = exp_ea;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; results are checked on the following falling edge.
  task automatic apply_vecs(input string tag);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      sb_q.push_back(vecs[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("%s[%0d] rdata", tag, i), sram_if.inst_sram_rdata, e.exp_rdata);
      check($sformatf("%s[%0d] acc_err", tag, i), 32'(sram_if.acc_err), 32'(e.exp_err));
      check($sformatf("%s[%0d] err_addr", tag, i), sram_if.err_addr, e.exp_err_addr);
      check($sformatf("%s[%0d] init_done", tag, i), 32'(sram_if.init_done), 32'd1);
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    vecs.delete();
  endtask

  // Count cycles from reset release to init_done while poking requests that must be ignored.
  task automatic run_init(input string tag);
    int cycles;
    cycles = 0;
    while (!sram_if.init_done && cycles < 100) begin
      if (cycles < 3)       drive(1'b1, 4'hf, BASE, 32'hdeadbeef);
      else if (cycles == 3) drive(1'b1, 4'h0, 32'h1d000000, 32'h0);
      else                  drive(1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      cycles++;
      if (!sram_if.init_done) begin
        check($sformatf("%s init acc_err c%0d", tag, cycles), 32'(sram_if.acc_err), 32'd0);
        check($sformatf("%s init rdata c%0d", tag, cycles), sram_if.inst_sram_rdata, 32'd0);
      end
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    check({tag, " init cycles"}, 32'(cycles), 32'd16);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rdata"}, sram_if.inst_sram_rdata, 32'h0);
    check({tag, " init_done"}, 32'(sram_if.init_done), 32'd0);
    check({tag, " acc_err"}, 32'(sram_if.acc_err), 32'd0);
    check({tag, " err_addr"}, sram_if.err_addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #12;
    check_zero("reset");

    @(negedge clk);
    resetn = 1'b1;
    run_init("first");

    for (int i = 0; i < 16; i++) add_row(1, 4'h0, BASE + 32'(4*i), 32'h0, 32'h0, 0, 32'h0);
    add_row(1, 4'hf, 32'h1c000008, 32'h02800413, WFIRST ? 32'h02800413 : 32'h0, 0, 32'h0);
    add_row(1, 4'h0, 32'h1c000008, 32'h0, 32'h02800413, 0, 32'h0);
    add_row(1, 4'hf, 32'h1c00000c, 32'haabbccdd, WFIRST ? 32'haabbccdd : 32'h02800413, 0, 32'h0);
    add_row(1, 4'h5, 32'h1c00000c, 32'h11223344, WFIRST ? 32'haa22cc44 : 32'h02800413, 0, 32'h0);
    add_row(1, 4'h0, 32'h1c00000c, 32'h0, 32'haa22cc44, 0, 32'h0);
    add_row(1, 4'hf, 32'h1c000004, 32'h13579bdf, WFIRST ? 32'h13579bdf : 32'haa22cc44, 0, 32'h0);
    add_row(1, 4'h0, 32'h1c000004, 32'h0, 32'h13579bdf, 0, 32'h0);
    for (int i = 0; i < 5; i++) add_row(0, 4'hf, 32'h1d000000, 32'hffffffff, 32'h13579bdf, 0, 32'h0);
    add_row(1, 4'h0, 32'h1d000000, 32'h0, 32'h13579bdf, 1, 32'h1d000000);
    add_row(1, 4'h0, 32'h1c000002, 32'h0, 32'h13579bdf, 1, 32'h1c000002);
    add_row(0, 4'h0, 32'h0, 32'h0, 32'h13579bdf, 0, 32'h1c000002);
    add_row(1, 4'hf, 32'h1c000040, 32'hffffffff, 32'h13579bdf, 1, 32'h1c000040);
    add_row(1, 4'h0, 32'h1c000000, 32'h0, 32'h0, 0, 32'h1c000040);
    add_row(1, 4'h0, 32'h1c000008, 32'h0, 32'h02800413, 0, 32'h1c000040);
    add_row(1, 4'h0, 32'h1c00000c, 32'h0, 32'haa22cc44, 0, 32'h1c000040);
    add_row(1, 4'h0, 32'h1c00000c, 32'h0, 32'haa22cc44, 0, 32'h1c000040);
    add_row(1, 4'h0, 32'h1c000004, 32'h0, 32'h13579bdf, 0, 32'h1c000040);
    apply_vecs("run");

    // Asynchronous reset in RUN with nonzero rdata and err_addr.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_zero("run reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("mid init init_done", 32'(sram_if.init_done), 32'd0);
    #2 resetn = 1'b0;
    #1 check_zero("mid init reset");
    @(negedge clk);
    resetn = 1'b1;
    run_init("restart");

    add_row(1, 4'h0, 32'h1c000008, 32'h0, 32'h0, 0, 32'h0);
    add_row(1, 4'h0, 32'h1c000000, 32'h0, 32'h0, 0, 32'h0);
    add_row(1, 4'h0, 32'h1c00000c, 32'h0, 32'h0, 0, 32'h0);
    add_row(1, 4'h0, 32'h1c000004, 32'h0, 32'h0, 0, 32'h0);
    apply_vecs("post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1c000000, meaning the byte address of word 0; low ADDR_W+2 bits SHALL be zero.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port inst_sram_en  input  1  access request this cycle.
REQ-006 SHALL have port inst_sram_we  input  4  byte write enables; 4'b0000 with en=1 is a read.
REQ-007 SHALL have port inst_sram_addr  input  32  byte address.
REQ-008 SHALL have port inst_sram_wdata  input  32  write data, byte i on bits [8i+7:8i].
REQ-009 SHALL have port inst_sram_rdata  output  32  read data.
REQ-010 SHALL have port init_done  output  1  high once zero-fill is complete.
REQ-011 SHALL have port acc_err  output  1  one-cycle pulse flagging a rejected access.
REQ-012 SHALL have port err_addr  output  32  address of the most recent rejected access.

Function
REQ-013 SHALL have a two-state FSM: INIT and RUN.
REQ-014 INIT SHALL zero one word per cycle, counter 0..2^ADDR_W-1, then enter RUN on the cycle after writing the last word. init_done SHALL be 1 exactly in RUN.
REQ-015 In INIT, requests SHALL be ignored: no write, rdata held, no acc_err.
REQ-016 An access is valid when en=1, addr[31:ADDR_W+2]==BASE_ADDR[31:ADDR_W+2] and addr[1:0]==0. Word index SHALL be addr[ADDR_W+1:2].
REQ-017 Valid read (we=0) SHALL drive rdata with mem[index] exactly one cycle later.
REQ-018 Valid write SHALL update only the bytes whose we bit is set, visible to a read issued the next cycle.
REQ-019 rdata SHALL hold its last value on any cycle without a valid read, including en=0, a write, or a rejected access. The upstream fetch stage depends on this while stalled.
REQ-020 A back-to-back read to the same or a different address SHALL return the correct word every cycle at full throughput.
REQ-021 A rejected access (en=1 in RUN and not valid) SHALL pulse acc_err one cycle later, load err_addr with the address, leave memory unchanged and hold rdata.
REQ-022 Counter wrap: the INIT counter SHALL be exactly ADDR_W bits and SHALL not restart after reaching RUN.

Reset
REQ-023 resetn low SHALL immediately force: FSM=INIT, counter=0, rdata=0, init_done=0, acc_err=0, err_addr=0.
REQ-024 resetn asserted mid-INIT or mid-RUN SHALL restart the zero-fill from word 0. Memory contents are not otherwise preserved.
REQ-025 After resetn deasserts, INIT SHALL take exactly 2^ADDR_W cycles.

Configuration
REQ-026 Macro INST_SRAM_WFIRST_EN SHALL select write behaviour for rdata.
- Defined: a valid write SHALL drive rdata one cycle later with the merged post-write word (write-first).
- Undefined: rdata SHALL hold per REQ-019 (no-change).
- All other behaviour SHALL be identical in both builds.

Verification
REQ-027 Release resetn, ADDR_W=4, then probe with reads -> init_done rises after exactly 16 cycles; read of 0x1c000000..0x1c00003c returns 0.
REQ-028 Write 0x1c000008 we=4'b1111 wdata=0x02800413, then read the same address -> rdata=0x02800413 one cycle after the read; rdata unchanged during the write cycle (no WFIRST).
REQ-029 Write 0xAABBCCDD full, then we=4'b0101 wdata=0x11223344, then read -> 0xAA22CC44.
REQ-030 Read 0x1c000004, then hold en=0 for 5 cycles -> rdata stable all 5 cycles.
REQ-031 Read 0x1d000000 and read 0x1c000002 -> acc_err pulses once each, err_addr=0x1d000000 then 0x1c000002, rdata unchanged.
REQ-032 Pull resetn low mid-INIT and again in RUN after writes -> outputs zero immediately; previously written word reads 0 after the new INIT completes. With INST_SRAM_WFIRST_EN defined, the write in REQ-028 shows 0x02800413 on rdata the following cycle.
